// File: rtl/fdiv_iter.sv
// Iterative 16-bit float divider (r = a / b), restoring mantissa division, one quotient bit per clock.
// Latency: fixed 10 clocks from start acceptance to done (11-cycle op rate); done pulses for one cycle.
// Backpressure: start is only accepted while busy is low; requests while busy are dropped.
module fdiv_iter #(
    parameter int EXP_BIAS = 127,
    parameter int QBITS    = 9
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] r,
    output logic        dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        NORM = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [3:0]  cnt;
    logic [8:0]  rem;
    logic [8:0]  quo;

    logic [7:0]  mb;
    logic        rem_ge;
    logic [8:0]  rem_diff;

    logic        sgn;
    logic [6:0]  frac;
    logic signed [9:0] e_raw;
    logic [15:0] r_nxt;
    logic        dz_nxt;

    assign busy = (state != IDLE);

    // Partial remainder always stays below 2*mb, so 9 bits suffice.
    assign mb       = {1'b1, b_q[6:0]};
    assign rem_ge   = (rem >= {1'b0, mb});
    assign rem_diff = rem_ge ? (rem - {1'b0, mb}) : rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = DIV;
            DIV:  if (cnt == 4'(QBITS - 1)) state_nxt = NORM;
            NORM: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result assembly; q[7] is guaranteed set when q[8] is clear.
    always_comb begin
        sgn   = a_q[15] ^ b_q[15];
        frac  = quo[8] ? quo[7:1] : quo[6:0];
        e_raw = 10'({2'b00, a_q[14:7]}) - 10'({2'b00, b_q[14:7]})
              + 10'(EXP_BIAS) - {9'd0, ~quo[8]};
        r_nxt  = {sgn, e_raw[7:0], frac};
        dz_nxt = 1'b0;
        if (b_q == 16'h0000) begin
            r_nxt  = {sgn, 8'hFF, 7'h7F};
            dz_nxt = 1'b1;
        end else if (a_q == 16'h0000) begin
            r_nxt = 16'h0000;
        end else if (e_raw <= 10'sd0) begin
            r_nxt = 16'h0000;
        end else if (e_raw > 10'sd255) begin
            r_nxt = {sgn, 8'hFF, 7'h7F};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= 16'h0000;
            b_q  <= 16'h0000;
            cnt  <= 4'd0;
            rem  <= 9'd0;
            quo  <= 9'd0;
            done <= 1'b0;
            r    <= 16'h0000;
            dz   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q <= a;
                        b_q <= b;
                        cnt <= 4'd0;
                        rem <= {2'b01, a[6:0]};
                        quo <= 9'd0;
                    end
                end
                DIV: begin
                    rem <= rem_diff << 1;
                    quo <= {quo[7:0], rem_ge};
                    cnt <= cnt + 4'd1;
                end
                NORM: begin
                    r    <= r_nxt;
                    dz   <= dz_nxt;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv_iter.sv
// Directed bench for fdiv_iter: stimulus pushes expected results, a monitor pops them on done.
module tb_fdiv_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] r;
    logic        dz;

    typedef struct packed {
        logic [15:0] r;
        logic        dz;
        logic [31:0] cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          done_cnt = 0;
    logic        prev_done = 1'b0;

    fdiv_iter dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .r     (r),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_done) chk("done_width", {31'd0, done}, 32'd0);
            if (done) begin
                exp_t e;
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("r", {16'd0, r}, {16'd0, e.r});
                    chk("dz", {31'd0, dz}, {31'd0, e.dz});
                    chk("latency", cyc, e.cyc);
                end
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    // If now=1 the caller is already at a negedge where start may be driven.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] er, input logic edz, input bit now);
        exp_t e;
        if (!now) @(negedge clk);
        start = 1'b1;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
        e.r   = er;
        e.dz  = edz;
        e.cyc = 32'(cyc + 10);
        exp_q.push_back(e);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit busy_ok;
        int d0;
        reset = 1'b1;
        start = 1'b0;
        a     = 16'h0000;
        b     = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_r", {16'd0, r}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // 1.0 / 2.0 with busy held for the whole operation
        issue(16'h3F80, 16'h4000, 16'h3F00, 1'b0, 1'b0);
        busy_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) busy_ok = 1'b0;
        end
        chk("busy_hold", {31'd0, busy_ok}, 32'd1);
        wait_done();

        issue(16'h3F80, 16'h4040, 16'h3EAA, 1'b0, 1'b0); wait_done();
        issue(16'hC0C0, 16'h4000, 16'hC040, 1'b0, 1'b0); wait_done();
        issue(16'h3F80, 16'h0000, 16'h7FFF, 1'b1, 1'b0); wait_done();
        issue(16'h0000, 16'h4000, 16'h0000, 1'b0, 1'b0); wait_done();
        issue(16'h0000, 16'h0000, 16'h7FFF, 1'b1, 1'b0); wait_done();
        issue(16'h0080, 16'h4000, 16'h0000, 1'b0, 1'b0); wait_done();
        issue(16'h7F80, 16'h3E80, 16'h7FFF, 1'b0, 1'b0); wait_done();
        issue(16'h7F00, 16'h3F00, 16'h7F80, 1'b0, 1'b0); wait_done();

        // Start pulsed mid-operation must be ignored
        issue(16'h4040, 16'h3FC0, 16'h4000, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        a     = 16'h3F80;
        b     = 16'h4040;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        // Start in the done cycle is accepted
        issue(16'h3F80, 16'h4000, 16'h3F00, 1'b0, 1'b1);
        wait_done();

        // Reset during the 5th DIV cycle aborts the operation
        issue(16'h4040, 16'h3FC0, 16'h4000, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_r", {16'd0, r}, 32'd0);
        chk("midrst_dz", {31'd0, dz}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        issue(16'h3F80, 16'h4040, 16'h3EAA, 1'b0, 1'b0);
        wait_done();

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
